// File: rtl/sync_ram_ctrl_m.sv
// rtl/sync_ram_ctrl_m.sv - single-port synchronous RAM with valid/ready requests, registered read response and init clear
// Optional per-byte parity storage and checking: SYNC_RAM_PARITY_EN
module sync_ram_ctrl_m #(
    parameter int                DWIDTH  = 8,
    parameter int                AWIDTH  = 5,
    parameter logic [DWIDTH-1:0] CLR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AWIDTH-1:0]     req_addr,
    input  logic [DWIDTH-1:0]     req_wdata,
    input  logic [DWIDTH/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DWIDTH-1:0]     rsp_rdata,
    output logic                  init_done
`ifdef SYNC_RAM_PARITY_EN
    ,
    input  logic                  inj_perr,
    output logic                  rsp_perr
`endif
);

    localparam int NB    = DWIDTH / 8;
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                init_done_q, init_done_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [DWIDTH-1:0]   mem_q [DEPTH];

    logic                req_ready_w;
    logic                wr_acc;
    logic                rd_acc;
    logic                mem_we;
    logic [AWIDTH-1:0]   mem_waddr;
    logic [DWIDTH-1:0]   mem_wdata;
    logic [NB-1:0]       mem_be;
    logic [DWIDTH-1:0]   rd_word;

`ifdef SYNC_RAM_PARITY_EN
    logic [NB-1:0]       par_q [DEPTH];
    logic                rsp_perr_q, rsp_perr_d;
    logic                mem_inj;
    logic [NB-1:0]       rd_par;
`endif

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        req_ready_w = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = req_addr;
        mem_wdata   = req_wdata;
        mem_be      = req_be;
`ifdef SYNC_RAM_PARITY_EN
        mem_inj     = 1'b0;
`endif
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = CLR_VAL;
                mem_be    = '1;
                clr_cnt_d = clr_cnt_q + AWIDTH'(1);
                if (clr_cnt_q == {AWIDTH{1'b1}}) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                // A held response blocks every request, writes included.
                req_ready_w = !rsp_valid_q || rsp_ready;
                mem_we      = req_valid && req_ready_w && req_write;
`ifdef SYNC_RAM_PARITY_EN
                mem_inj     = inj_perr;
`endif
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign wr_acc = req_valid && req_ready_w && req_write;
    assign rd_acc = req_valid && req_ready_w && !req_write;
    assign rd_word = mem_q[req_addr];

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        if (rd_acc) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd_word;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

`ifdef SYNC_RAM_PARITY_EN
    always_comb begin
        rd_par = '0;
        for (int i = 0; i < NB; i++) begin
            rd_par[i] = ^rd_word[8*i +: 8];
        end
        rsp_perr_d = rsp_perr_q;
        if (rd_acc) begin
            rsp_perr_d = |(rd_par ^ par_q[req_addr]);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef SYNC_RAM_PARITY_EN
            rsp_perr_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef SYNC_RAM_PARITY_EN
            rsp_perr_q  <= rsp_perr_d;
`endif
        end
    end

    // Storage has no reset; the INIT sweep defines its contents.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
`ifdef SYNC_RAM_PARITY_EN
                    par_q[mem_waddr][i] <= (^mem_wdata[8*i +: 8]) ^ mem_inj;
`endif
                end
            end
        end
    end

    assign req_ready = req_ready_w;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;
`ifdef SYNC_RAM_PARITY_EN
    assign rsp_perr  = rsp_perr_q;
`endif

endmodule

// File: tb/tb_sync_ram_ctrl_m.sv
// tb/tb_sync_ram_ctrl_m.sv - scoreboard bench for sync_ram_ctrl_m with a behavioural memory model
module tb_sync_ram_ctrl_m;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] CLR = 32'hA5A5_A5A5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [NB-1:0] req_be = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          inj_perr = 1'b0;
    logic          rsp_perr;

    sync_ram_ctrl_m #(.DWIDTH(DW), .AWIDTH(AW), .CLR_VAL(CLR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
`ifdef SYNC_RAM_PARITY_EN
        ,
        .inj_perr  (inj_perr),
        .rsp_perr  (rsp_perr)
`endif
    );

`ifndef SYNC_RAM_PARITY_EN
    assign rsp_perr = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    logic [NB-1:0] model_bad [DEPTH];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            seen_front = 1'b0;
    bit            run_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: peek at every visible response, retire it on handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                if (!seen_front) begin
                    check("rsp_latency", 64'(cyc), 64'(exp_q[0].due));
                    seen_front = 1'b1;
                end
                check("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].data));
`ifdef SYNC_RAM_PARITY_EN
                check("rsp_perr", 64'(rsp_perr), 64'(exp_q[0].perr));
`endif
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    seen_front = 1'b0;
                end
            end
        end
    end

    task automatic step(input bit v, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [NB-1:0] be,
                        input bit inj, input bit rdy, output bit acc);
        bit exp_valid;
        exp_t e;
        @(posedge clk);
        #1;
        exp_valid = (exp_q.size() != 0);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        inj_perr  = inj;
        rsp_ready = rdy;
        @(negedge clk);
        if (run_mode) begin
            check("req_ready", 64'(req_ready), 64'(!exp_valid || rdy));
        end
        acc = v && req_ready;
        if (acc) begin
            if (w) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        model_mem[a][8*i +: 8] = d[8*i +: 8];
                        model_bad[a][i] = inj;
                    end
                end
            end else begin
                e.data = model_mem[a];
                e.perr = |model_bad[a];
                e.due  = cyc + 1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        inj_perr  = 1'b0;
        run_mode  = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        exp_q.delete();
        seen_front = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = CLR;
            model_bad[i] = '0;
        end
        rst_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk);
            #1;
            check("init_done_timing", 64'(init_done), 64'(i == DEPTH));
            check("init_req_ready", 64'(req_ready), 64'(i == DEPTH));
        end
        run_mode = 1'b1;
    endtask

    initial begin
        bit acc;
        do_reset();

        step(1'b1, 1'b0, 5'd0,  '0, '0, 1'b0, 1'b1, acc);
        step(1'b1, 1'b0, 5'd17, '0, '0, 1'b0, 1'b1, acc);
        step(1'b1, 1'b0, 5'd31, '0, '0, 1'b0, 1'b1, acc);
        check("clr_read_31", 64'(rsp_rdata), 64'(CLR));
        idle(2);

        step(1'b1, 1'b1, 5'd3, 32'h1122_3344, 4'b1111, 1'b0, 1'b1, acc);
        step(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 4'b0101, 1'b0, 1'b1, acc);
        step(1'b1, 1'b0, 5'd3, '0, '0, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
        check("be_merge", 64'(rsp_rdata), 64'h11FF_33FF);
        step(1'b1, 1'b1, 5'd4, 32'hDEAD_BEEF, 4'b0000, 1'b0, 1'b1, acc);
        step(1'b1, 1'b0, 5'd4, '0, '0, 1'b0, 1'b1, acc);
        idle(1);

        step(1'b1, 1'b1, 5'd7, 32'h0000_003C, 4'b1111, 1'b0, 1'b1, acc);
        step(1'b1, 1'b0, 5'd7, '0, '0, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
        check("raw_valid", 64'(rsp_valid), 64'd1);
        check("raw_data", 64'(rsp_rdata), 64'h3C);

        step(1'b1, 1'b0, 5'd1, '0, '0, 1'b0, 1'b0, acc);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 5'd5, 32'hCAFE_0005, 4'b1111, 1'b0, 1'b0, acc);
            check("bp_stall", 64'(acc), 64'd0);
            check("bp_valid", 64'(rsp_valid), 64'd1);
        end
        step(1'b1, 1'b1, 5'd5, 32'hCAFE_0005, 4'b1111, 1'b0, 1'b1, acc);
        check("bp_release_accept", 64'(acc), 64'd1);
        step(1'b1, 1'b0, 5'd5, '0, '0, 1'b0, 1'b1, acc);
        idle(1);

        step(1'b1, 1'b1, 5'd9, 32'h0000_0055, 4'b1111, 1'b0, 1'b1, acc);
        step(1'b1, 1'b0, 5'd9, '0, '0, 1'b0, 1'b0, acc);
        do_reset();
        step(1'b1, 1'b0, 5'd9, '0, '0, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
        check("reset_reclear", 64'(rsp_rdata), 64'(CLR));

`ifdef SYNC_RAM_PARITY_EN
        step(1'b1, 1'b1, 5'd2, 32'h0000_000F, 4'b1111, 1'b1, 1'b1, acc);
        step(1'b1, 1'b0, 5'd2, '0, '0, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
        check("perr_injected", 64'(rsp_perr), 64'd1);
        step(1'b1, 1'b1, 5'd2, 32'h0000_000F, 4'b1111, 1'b0, 1'b1, acc);
        step(1'b1, 1'b0, 5'd2, '0, '0, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
        check("perr_cleared", 64'(rsp_perr), 64'd0);
`endif

        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, DEPTH - 1)), $urandom, NB'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, acc);
        end

        idle(4);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
